// File: rtl/tlb_refill_walker.sv
`timescale 1ns/1ps
// tlb_refill_walker
// Refills one TLB entry after a miss. It reads the even/odd PTE pair for the
// faulting VPN2 from a linear page table, then writes the entry through the
// TLB write port. If neither PTE is valid, it pulses fault instead.
//
// Ports
//   clk, res                  clock and synchronous active-high reset
//   missValid/missVAddr/      refill request; accepted only while idle
//   missAsid/ptBase
//   wired                     lowest replaceable index (low bits only)
//   busy                      high whenever a walk is in progress
//   memReq/memAddr            level read request and word address
//   memReady/memRData         read completion and PTE data
//   tlbWe/tlbIndex/entry*/    TLB write port
//   pageMaskOut
//   done/fault                one-cycle completion / page-fault pulses
module tlb_refill_walker #(
  parameter int ENTRY_ADDR_WIDTH = 3
) (
  input  logic        clk,
  input  logic        res,
  input  logic        missValid,
  input  logic [31:0] missVAddr,
  input  logic [7:0]  missAsid,
  input  logic [31:0] ptBase,
  input  logic [31:0] wired,
  output logic        busy,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memReady,
  input  logic [31:0] memRData,
  output logic        tlbWe,
  output logic [31:0] tlbIndex,
  output logic [31:0] entryHiOut,
  output logic [31:0] entryLo0Out,
  output logic [31:0] entryLo1Out,
  output logic [31:0] pageMaskOut,
  output logic        done,
  output logic        fault
);

  localparam logic [ENTRY_ADDR_WIDTH-1:0] RAND_TOP = '1;
  localparam logic [ENTRY_ADDR_WIDTH-1:0] RAND_ONE = {{(ENTRY_ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, RD_EVEN, RD_ODD, WRITE, FAULT} state_t;

  state_t                      state_q, state_d;
  logic [18:0]                 vpn2_q, vpn2_d;
  logic [7:0]                  asid_q, asid_d;
  logic [31:0]                 base_q, base_d;
  logic [31:0]                 hi_q, hi_d;
  logic [31:0]                 lo0_q, lo0_d;
  logic [31:0]                 lo1_q, lo1_d;
  logic [ENTRY_ADDR_WIDTH-1:0] rand_q, rand_d;
  logic [ENTRY_ADDR_WIDTH-1:0] wired_lo;
  logic [31:0]                 even_addr;
  logic [31:0]                 odd_addr;
  logic                        unused_bits;

  // The page offset and the upper wired bits have no effect on the walk.
  assign unused_bits = ^{missVAddr[12:0], wired[31:ENTRY_ADDR_WIDTH]};
  assign wired_lo    = wired[ENTRY_ADDR_WIDTH-1:0];

  // Each VPN2 owns an 8-byte PTE pair. Both additions wrap modulo 2^32.
  assign even_addr = base_q + {10'b0, vpn2_q, 3'b000};
  assign odd_addr  = even_addr + 32'd4;

  assign busy        = (state_q != IDLE);
  assign tlbIndex    = {{(32-ENTRY_ADDR_WIDTH){1'b0}}, rand_q};
  assign entryHiOut  = hi_q;
  assign entryLo0Out = lo0_q;
  assign entryLo1Out = lo1_q;
  assign pageMaskOut = 32'h0;

  // Replacement counter. It free-runs every cycle and wraps back to the top
  // once it reaches the wired boundary.
  always_comb begin
    rand_d = (rand_q <= wired_lo) ? RAND_TOP : rand_q - RAND_ONE;
  end

  always_comb begin
    state_d = state_q;
    vpn2_d  = vpn2_q;
    asid_d  = asid_q;
    base_d  = base_q;
    hi_d    = hi_q;
    lo0_d   = lo0_q;
    lo1_d   = lo1_q;
    memReq  = 1'b0;
    memAddr = 32'h0;
    tlbWe   = 1'b0;
    done    = 1'b0;
    fault   = 1'b0;
    case (state_q)
      IDLE: begin
        if (missValid) begin
          vpn2_d  = missVAddr[31:13];
          asid_d  = missAsid;
          base_d  = ptBase;
          state_d = RD_EVEN;
        end
      end
      RD_EVEN: begin
        memReq  = 1'b1;
        memAddr = even_addr;
        if (memReady) begin
          lo0_d   = memRData;
          state_d = RD_ODD;
        end
      end
      RD_ODD: begin
        memReq  = 1'b1;
        memAddr = odd_addr;
        if (memReady) begin
          lo1_d = memRData;
          // V is bit 1 of each PTE. A fault leaves entryHi untouched.
          if (!lo0_q[1] && !memRData[1]) begin
            state_d = FAULT;
          end else begin
            hi_d    = {vpn2_q, 5'b0, asid_q};
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        tlbWe   = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      FAULT: begin
        fault   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      vpn2_q  <= '0;
      asid_q  <= '0;
      base_q  <= '0;
      hi_q    <= '0;
      lo0_q   <= '0;
      lo1_q   <= '0;
      rand_q  <= RAND_TOP;
    end else begin
      state_q <= state_d;
      vpn2_q  <= vpn2_d;
      asid_q  <= asid_d;
      base_q  <= base_d;
      hi_q    <= hi_d;
      lo0_q   <= lo0_d;
      lo1_q   <= lo1_d;
      rand_q  <= rand_d;
    end
  end

endmodule

// File: doc/tlb_refill_walker.md
Name: tlb_refill_walker

Overview:
Hardware refill engine that services TLB misses by walking a linear page table in memory. It fetches the even/odd PTE pair for the faulting VPN2 and writes one entry into the TLB array through its write port (pageMask, entryHi, entryLo0/1, index, we). It sits between the MMU miss path and the memory read port and signals a page fault instead of writing when neither PTE is valid.

Parameters:
ENTRY_ADDR_WIDTH, 3, log2 of TLB entry count; ENTRY_COUNT = 1 << ENTRY_ADDR_WIDTH.

Ports:
clk  input  1  clock; all state changes on the rising edge.
res  input  1  synchronous active-high reset.
missValid  input  1  request a refill for missVAddr/missAsid; sampled only in IDLE.
missVAddr  input  32  faulting virtual address.
missAsid  input  8  ASID of the faulting access.
ptBase  input  32  page table base byte address; sampled with the request.
wired  input  32  lowest replaceable index; bits above ENTRY_ADDR_WIDTH-1 are ignored.
busy  output  1  high in every state except IDLE.
memReq  output  1  memory read request.
memAddr  output  32  word read address; stable while memReq is high.
memReady  input  1  read completes this cycle; memRData is valid.
memRData  input  32  PTE data in EntryLo format: PFN[25:6], C[5:3], D[2], V[1], G[0].
tlbWe  output  1  one-cycle TLB write strobe.
tlbIndex  output  32  write index, zero-extended.
entryHiOut  output  32  {VPN2[31:13], 5'b0, ASID[7:0]}.
entryLo0Out  output  32  even PTE.
entryLo1Out  output  32  odd PTE.
pageMaskOut  output  32  always 0 (4 KB pages).
done  output  1  one-cycle pulse, coincident with tlbWe.
fault  output  1  one-cycle pulse when both PTEs are invalid; no TLB write occurs.

Behaviour:
- States: IDLE, RD_EVEN, RD_ODD, WRITE, FAULT.
- Reset (sync, res=1): state goes to IDLE. Outputs memReq, tlbWe, done, fault, busy go to 0. memAddr, entryHiOut, entryLo0Out, entryLo1Out and pageMaskOut go to 0. The random counter goes to ENTRY_COUNT-1. Reset mid-walk aborts immediately: memReq drops the next cycle and no TLB write happens.
- IDLE: if missValid=1, latch vaddr, asid and ptBase, then go to RD_EVEN. Otherwise stay in IDLE.
- PTE address: evenAddr = ptBase + {missVAddr[31:13], 3'b000}, mod 2^32. oddAddr = evenAddr + 4, also mod 2^32.
- RD_EVEN: memReq=1, memAddr=evenAddr. When memReady=1, capture memRData into entryLo0Out and go to RD_ODD. Otherwise hold.
- RD_ODD: memReq=1, memAddr=oddAddr. When memReady=1, capture entryLo1Out. If V of both PTEs is 0, go to FAULT; else go to WRITE.
- WRITE: tlbWe=1, done=1 for one cycle. tlbIndex equals the random counter value in that cycle. Return to IDLE.
- FAULT: fault=1 for one cycle, tlbWe=0. Return to IDLE.
- Minimum latency: missValid accepted at cycle T with memReady tied high gives tlbWe at T+3. Each memReady wait cycle adds 1.
- memReq is a level signal. A new address is presented in the cycle after memReady. memReady while memReq=0 is ignored.
- missValid while busy=1 is ignored; no queueing.
- Random counter: updates every cycle regardless of state, mod ENTRY_COUNT.
  - If random <= wired', next value is ENTRY_COUNT-1; else random-1.
  - wired' = wired[ENTRY_ADDR_WIDTH-1:0].
  - If wired' = ENTRY_COUNT-1, the counter stays at ENTRY_COUNT-1.
- Outputs entryHiOut, entryLo0Out, entryLo1Out, pageMaskOut and tlbIndex are valid whenever tlbWe=1. entryHi/Lo outputs hold their last values otherwise.
- G bits pass through unchanged. The TLB ANDs the two G bits itself.

Test Plan:
1. Basic refill, ptBase=0x8010_0000, missVAddr=0x0040_3ABC, missAsid=0x05, memReady tied 1:
   - Reads at 0x8010_1008 then 0x8010_100C.
   - With rdata 0x0000_1046 / 0x0000_1086: tlbWe at T+3 with entryHiOut=0x0040_2005, entryLo0Out=0x0000_1046, entryLo1Out=0x0000_1086, pageMaskOut=0.
   - done=1 in the same cycle.
2. Wait states: memReady low for 4 cycles on each read. memAddr stays stable throughout, tlbWe occurs at T+11, and exactly 2 reads are issued.
3. Fault: both PTEs=0x0000_1040 (V=0). fault pulses once, tlbWe stays 0, and busy returns to 0 the next cycle.
4. Random/wired with wired=5:
   - Counter sequence after reset is 7,6,5,7,6,5...
   - The tlbIndex of a refill matches the counter in its WRITE cycle.
   - With wired=7, tlbIndex is always 7.
5. Reset mid-walk: assert res in RD_ODD. Next cycle memReq=0 and busy=0, no tlbWe, and the counter reads 7.
6. missValid held high across a walk: exactly one refill per accept, and the next walk starts only from IDLE. ptBase=0xFFFF_FFF8 with VPN2=0 produces an odd-PTE read at 0xFFFF_FFFC; a VPN2 of 1 with the same ptBase reads 0x0000_0000 (wrap).
